// File: rtl/spectrum_pulse_accumulator_pkg.sv
// Shared definitions for the pulse accumulator: default sizes, FSM encoding
// and user-register field geometry.
package spectrum_pulse_accumulator_pkg;

   localparam int FFT_N_DEF  = 512;
   localparam int MAX_RB_DEF = 16;
   localparam int DW_IN_DEF  = 32;
   localparam int DW_ACC_DEF = 40;

   // UR_nRangeBins / UR_nACC_Pulses field width; UR_CMD bit that arms a frame
   localparam int UR_FIELD_W        = 16;
   localparam int UR_CMD_ENABLE_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DUMP  = 2'd2
   } state_e;

endpackage

// File: rtl/spectrum_pulse_accumulator_dpram.sv
// Simple dual-port accumulator RAM, one write port and one read port with
// 1-cycle registered read (read-first on address collision).
module spectrum_pulse_accumulator_dpram #(
   parameter int DW    = 40,
   parameter int AW    = 13,
   parameter int DEPTH = 8192
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      rdata_q <= mem_q[raddr_i];
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spectrum_pulse_accumulator.sv
// Sums FFT power spectra bin-by-bin over N pulses in one RAM via a
// read-modify-write pipeline, then streams the frame out through a 2-entry skid.
module spectrum_pulse_accumulator
   import spectrum_pulse_accumulator_pkg::*;
#(
   parameter int FFT_N  = FFT_N_DEF,
   parameter int MAX_RB = MAX_RB_DEF,
   parameter int DW_IN  = DW_IN_DEF,
   parameter int DW_ACC = DW_ACC_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [UR_FIELD_W-1:0] n_range_bins_i,
   input  logic [UR_FIELD_W-1:0] n_acc_pulses_i,
   input  logic [DW_IN-1:0]      pwr_i,
   input  logic                  pwr_valid_i,
   input  logic                  pwr_last_i,
   output logic [DW_ACC-1:0]     acc_o,
   output logic                  acc_valid_o,
   input  logic                  acc_ready_i,
   output logic                  acc_last_o,
   output logic                  busy_o,
   output logic                  overrun_o,
   output logic                  sat_o,
   output logic                  frame_err_o
);

   localparam int BW    = $clog2(FFT_N);
   localparam int RW    = (MAX_RB > 1) ? $clog2(MAX_RB) : 1;
   localparam int AW    = BW + RW;
   localparam int DEPTH = MAX_RB * FFT_N;

   state_e                state_q, state_d;
   logic [BW-1:0]         bin_idx_q, bin_idx_d;
   logic [RW-1:0]         rb_idx_q, rb_idx_d;
   logic [UR_FIELD_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [RW-1:0]         nrb_m1_q, nrb_m1_d;
   logic [UR_FIELD_W-1:0] nacc_m1_q, nacc_m1_d;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_first_q, s1_first_d;
   logic [DW_IN-1:0]      s1_pwr_q, s1_pwr_d;
   logic [AW-1:0]         rd_addr_q;
   logic                  s2_valid_q, s2_valid_d;
   logic [AW-1:0]         s2_addr_q;
   logic [DW_ACC-1:0]     s2_data_q, s2_data_d;
   logic                  s3_valid_q;
   logic [AW-1:0]         s3_addr_q;
   logic [DW_ACC-1:0]     s3_data_q;

   logic                  rd_done_q, rd_done_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rd_pend_last_q, rd_pend_last_d;
   logic [1:0]            f_cnt_q, f_cnt_d;
   logic [DW_ACC-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;

   logic                  overrun_q, overrun_d;
   logic                  sat_q, sat_d;
   logic                  frame_err_q, frame_err_d;

   logic [AW-1:0]         rd_addr;
   logic [DW_ACC-1:0]     ram_rd_data;
   logic [DW_ACC-1:0]     fwd_data;
   logic [DW_ACC-1:0]     acc_base;
   logic [DW_ACC:0]       sum;
   logic                  bin_last, rb_last, pulse_last;
   logic                  dump_pop, dump_issue;
   logic [2:0]            dump_occ;

   assign rd_addr    = {rb_idx_q, bin_idx_q};
   assign bin_last   = (bin_idx_q == BW'(FFT_N - 1));
   assign rb_last    = (rb_idx_q == nrb_m1_q);
   assign pulse_last = (pulse_cnt_q == nacc_m1_q);

   spectrum_pulse_accumulator_dpram #(
      .DW    (DW_ACC),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (s2_valid_q),
      .waddr_i (s2_addr_q),
      .wdata_i (s2_data_q),
      .raddr_i (rd_addr),
      .rdata_o (ram_rd_data)
   );

   // A read may still be missing a write that is in stage2 or was committed on
   // the same edge as the read (s3); the newer of the two wins.
   always_comb begin
      fwd_data = ram_rd_data;
      if (s2_valid_q && (s2_addr_q == rd_addr_q)) begin
         fwd_data = s2_data_q;
      end else if (s3_valid_q && (s3_addr_q == rd_addr_q)) begin
         fwd_data = s3_data_q;
      end
      acc_base  = s1_first_q ? '0 : fwd_data;
      sum       = {1'b0, acc_base} + {{(DW_ACC + 1 - DW_IN){1'b0}}, s1_pwr_q};
      s2_data_d = sum[DW_ACC] ? '1 : sum[DW_ACC-1:0];
   end

   assign dump_pop   = (f_cnt_q != 2'd0) && acc_ready_i;
   assign dump_occ   = {1'b0, f_cnt_q} + {2'b00, rd_pend_q} - {2'b00, dump_pop};
   assign dump_issue = (state_q == ST_DUMP) && !rd_done_q && (dump_occ < 3'd2);

   always_comb begin
      state_d        = state_q;
      bin_idx_d      = bin_idx_q;
      rb_idx_d       = rb_idx_q;
      pulse_cnt_d    = pulse_cnt_q;
      nrb_m1_d       = nrb_m1_q;
      nacc_m1_d      = nacc_m1_q;
      s1_valid_d     = 1'b0;
      s1_first_d     = (pulse_cnt_q == '0);
      s1_pwr_d       = pwr_i;
      s2_valid_d     = s1_valid_q;
      rd_done_d      = rd_done_q;
      rd_pend_d      = 1'b0;
      rd_pend_last_d = 1'b0;
      f_cnt_d        = f_cnt_q;
      head_data_d    = head_data_q;
      head_last_d    = head_last_q;
      tail_data_d    = tail_data_q;
      tail_last_d    = tail_last_q;
      overrun_d      = overrun_q;
      sat_d          = sat_q;
      frame_err_d    = frame_err_q;

      if (s1_valid_q && sum[DW_ACC]) begin
         sat_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d     = ST_ACCUM;
               bin_idx_d   = '0;
               rb_idx_d    = '0;
               pulse_cnt_d = '0;
               rd_done_d   = 1'b0;
               if (n_range_bins_i == '0) begin
                  nrb_m1_d = '0;
               end else if (n_range_bins_i > UR_FIELD_W'(MAX_RB)) begin
                  nrb_m1_d = RW'(MAX_RB - 1);
               end else begin
                  nrb_m1_d = RW'(n_range_bins_i - 1'b1);
               end
               nacc_m1_d = (n_acc_pulses_i == '0) ? '0 : (n_acc_pulses_i - 1'b1);
            end
         end

         // pwr_last_i forces a bin wrap so a misaligned stream resynchronises
         ST_ACCUM: begin
            if (pwr_valid_i) begin
               s1_valid_d = 1'b1;
               if (bin_last != pwr_last_i) begin
                  frame_err_d = 1'b1;
               end
               if (bin_last || pwr_last_i) begin
                  bin_idx_d = '0;
                  if (rb_last) begin
                     rb_idx_d = '0;
                     if (pulse_last) begin
                        pulse_cnt_d = '0;
                        state_d     = ST_DUMP;
                     end else begin
                        pulse_cnt_d = pulse_cnt_q + 1'b1;
                     end
                  end else begin
                     rb_idx_d = rb_idx_q + 1'b1;
                  end
               end else begin
                  bin_idx_d = bin_idx_q + 1'b1;
               end
            end
         end

         ST_DUMP: begin
            if (pwr_valid_i) begin
               overrun_d = 1'b1;
            end
            if (dump_issue) begin
               rd_pend_d      = 1'b1;
               rd_pend_last_d = bin_last && rb_last;
               if (bin_last) begin
                  bin_idx_d = '0;
                  if (rb_last) begin
                     rb_idx_d  = '0;
                     rd_done_d = 1'b1;
                  end else begin
                     rb_idx_d = rb_idx_q + 1'b1;
                  end
               end else begin
                  bin_idx_d = bin_idx_q + 1'b1;
               end
            end
            // Skid update: returning read data lands in head or tail, pop shifts tail up
            if (dump_pop) begin
               if (rd_pend_q) begin
                  if (f_cnt_q == 2'd2) begin
                     head_data_d = tail_data_q;
                     head_last_d = tail_last_q;
                     tail_data_d = fwd_data;
                     tail_last_d = rd_pend_last_q;
                  end else begin
                     head_data_d = fwd_data;
                     head_last_d = rd_pend_last_q;
                  end
               end else begin
                  head_data_d = tail_data_q;
                  head_last_d = tail_last_q;
                  f_cnt_d     = f_cnt_q - 1'b1;
               end
            end else if (rd_pend_q) begin
               if (f_cnt_q == 2'd0) begin
                  head_data_d = fwd_data;
                  head_last_d = rd_pend_last_q;
               end else begin
                  tail_data_d = fwd_data;
                  tail_last_d = rd_pend_last_q;
               end
               f_cnt_d = f_cnt_q + 1'b1;
            end
            if (dump_pop && head_last_q) begin
               state_d   = ST_IDLE;
               f_cnt_d   = 2'd0;
               rd_done_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         bin_idx_q      <= '0;
         rb_idx_q       <= '0;
         pulse_cnt_q    <= '0;
         nrb_m1_q       <= '0;
         nacc_m1_q      <= '0;
         s1_valid_q     <= 1'b0;
         s1_first_q     <= 1'b0;
         s1_pwr_q       <= '0;
         rd_addr_q      <= '0;
         s2_valid_q     <= 1'b0;
         s2_addr_q      <= '0;
         s2_data_q      <= '0;
         s3_valid_q     <= 1'b0;
         s3_addr_q      <= '0;
         s3_data_q      <= '0;
         rd_done_q      <= 1'b0;
         rd_pend_q      <= 1'b0;
         rd_pend_last_q <= 1'b0;
         f_cnt_q        <= 2'd0;
         head_data_q    <= '0;
         head_last_q    <= 1'b0;
         tail_data_q    <= '0;
         tail_last_q    <= 1'b0;
         overrun_q      <= 1'b0;
         sat_q          <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bin_idx_q      <= bin_idx_d;
         rb_idx_q       <= rb_idx_d;
         pulse_cnt_q    <= pulse_cnt_d;
         nrb_m1_q       <= nrb_m1_d;
         nacc_m1_q      <= nacc_m1_d;
         s1_valid_q     <= s1_valid_d;
         s1_first_q     <= s1_first_d;
         s1_pwr_q       <= s1_pwr_d;
         rd_addr_q      <= rd_addr;
         s2_valid_q     <= s2_valid_d;
         s2_addr_q      <= rd_addr_q;
         s2_data_q      <= s2_data_d;
         s3_valid_q     <= s2_valid_q;
         s3_addr_q      <= s2_addr_q;
         s3_data_q      <= s2_data_q;
         rd_done_q      <= rd_done_d;
         rd_pend_q      <= rd_pend_d;
         rd_pend_last_q <= rd_pend_last_d;
         f_cnt_q        <= f_cnt_d;
         head_data_q    <= head_data_d;
         head_last_q    <= head_last_d;
         tail_data_q    <= tail_data_d;
         tail_last_q    <= tail_last_d;
         overrun_q      <= overrun_d;
         sat_q          <= sat_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign acc_o       = head_data_q;
   assign acc_valid_o = (f_cnt_q != 2'd0);
   assign acc_last_o  = acc_valid_o && head_last_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign overrun_o   = overrun_q;
   assign sat_o       = sat_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spectrum_pulse_accumulator.sv
// Directed self-checking bench for spectrum_pulse_accumulator with a small
// frame geometry (16 points x up to 4 range bins, 33-bit accumulator).
module tb_spectrum_pulse_accumulator;

   localparam int FFT_N  = 16;
   localparam int MAX_RB = 4;
   localparam int DW_IN  = 32;
   localparam int DW_ACC = 33;

   logic              clk;
   logic              rst_i;
   logic              enable_i;
   logic [15:0]       n_range_bins_i;
   logic [15:0]       n_acc_pulses_i;
   logic [DW_IN-1:0]  pwr_i;
   logic              pwr_valid_i;
   logic              pwr_last_i;
   logic [DW_ACC-1:0] acc_o;
   logic              acc_valid_o;
   logic              acc_ready_i;
   logic              acc_last_o;
   logic              busy_o;
   logic              overrun_o;
   logic              sat_o;
   logic              frame_err_o;

   int checks = 0;
   int errors = 0;

   logic [DW_ACC-1:0] got_data [128];
   logic              got_last [128];
   int                n_got;
   int                first_valid;
   int                stall_errs;
   logic              timed_out;

   spectrum_pulse_accumulator #(
      .FFT_N  (FFT_N),
      .MAX_RB (MAX_RB),
      .DW_IN  (DW_IN),
      .DW_ACC (DW_ACC)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .enable_i       (enable_i),
      .n_range_bins_i (n_range_bins_i),
      .n_acc_pulses_i (n_acc_pulses_i),
      .pwr_i          (pwr_i),
      .pwr_valid_i    (pwr_valid_i),
      .pwr_last_i     (pwr_last_i),
      .acc_o          (acc_o),
      .acc_valid_o    (acc_valid_o),
      .acc_ready_i    (acc_ready_i),
      .acc_last_o     (acc_last_o),
      .busy_o         (busy_o),
      .overrun_o      (overrun_o),
      .sat_o          (sat_o),
      .frame_err_o    (frame_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_sample(input logic [DW_IN-1:0] val, input logic last);
      pwr_i       = val;
      pwr_valid_i = 1'b1;
      pwr_last_i  = last;
      @(posedge clk);
      #1;
      pwr_valid_i = 1'b0;
      pwr_last_i  = 1'b0;
   endtask

   // Arms a frame, then scribbles the size registers to show they were latched
   task automatic start_frame(input logic [15:0] nrb, input logic [15:0] nacc);
      n_range_bins_i = nrb;
      n_acc_pulses_i = nacc;
      enable_i       = 1'b1;
      @(posedge clk);
      #1;
      enable_i       = 1'b0;
      n_range_bins_i = 16'd1;
      n_acc_pulses_i = 16'd2;
   endtask

   // mode 0: constant cval; mode 1: address k carries k+p
   task automatic send_pulse(input int p, input int mode, input logic [DW_IN-1:0] cval,
                             input int nrb);
      for (int k = 0; k < nrb * FFT_N; k++) begin
         apply_sample((mode == 1) ? DW_IN'(k + p) : cval, (k % FFT_N) == FFT_N - 1);
      end
   endtask

   task automatic dump_collect(input logic rand_ready);
      logic              r;
      logic              prev_stall;
      logic [DW_ACC-1:0] prev_data;
      logic              done;
      n_got       = 0;
      first_valid = -1;
      stall_errs  = 0;
      timed_out   = 1'b1;
      prev_stall  = 1'b0;
      prev_data   = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         acc_ready_i = r;
         if (prev_stall && (acc_valid_o !== 1'b1 || acc_o !== prev_data)) begin
            stall_errs++;
         end
         if (acc_valid_o === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            if (r && n_got < 128) begin
               got_data[n_got] = acc_o;
               got_last[n_got] = acc_last_o;
               n_got++;
            end
         end
         prev_stall = acc_valid_o && !r;
         prev_data  = acc_o;
         done       = acc_valid_o && r && acc_last_o;
         @(posedge clk);
         #1;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      acc_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_cycles(2);
      rst_i = 1'b0;
      checks++; if (acc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", acc_valid_o); end
      checks++; if (acc_o !== '0) begin errors++; $display("[TB] FAIL reset_acc: got %0h expected 0", acc_o); end
      checks++; if (acc_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", acc_last_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if ({overrun_o, sat_o, frame_err_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {overrun_o, sat_o, frame_err_o}); end
   endtask

   task automatic test_constant();
      start_frame(16'd2, 16'd3);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL const_busy: got %b expected 1", busy_o); end
      for (int p = 0; p < 3; p++) begin
         send_pulse(p, 0, 32'd5, 2);
         if (p < 2) idle_cycles(2);
      end
      dump_collect(1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL const_timeout: got %b expected 0", timed_out); end
      checks++; if (n_got !== 32) begin errors++; $display("[TB] FAIL const_count: got %0d expected 32", n_got); end
      checks++; if (first_valid !== 2) begin errors++; $display("[TB] FAIL const_latency: got %0d expected 2", first_valid); end
      for (int i = 0; i < n_got && i < 32; i++) begin
         checks++; if (got_data[i] !== 33'd15) begin errors++; $display("[TB] FAIL const_word[%0d]: got %0d expected 15", i, got_data[i]); end
         checks++; if (got_last[i] !== (i == 31)) begin errors++; $display("[TB] FAIL const_last[%0d]: got %b expected %b", i, got_last[i], (i == 31)); end
      end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL const_busy_end: got %b expected 0", busy_o); end
      checks++; if ({overrun_o, sat_o, frame_err_o} !== 3'b000) begin errors++; $display("[TB] FAIL const_flags: got %b expected 000", {overrun_o, sat_o, frame_err_o}); end
   endtask

   task automatic test_back_to_back();
      start_frame(16'd2, 16'd3);
      for (int p = 0; p < 3; p++) send_pulse(p, 1, '0, 2);
      dump_collect(1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_timeout: got %b expected 0", timed_out); end
      checks++; if (n_got !== 32) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 32", n_got); end
      for (int i = 0; i < n_got && i < 32; i++) begin
         checks++; if (got_data[i] !== DW_ACC'(3 * i + 3)) begin errors++; $display("[TB] FAIL b2b_word[%0d]: got %0d expected %0d", i, got_data[i], 3 * i + 3); end
      end
   endtask

   task automatic test_random_ready();
      start_frame(16'd2, 16'd3);
      for (int p = 0; p < 3; p++) begin
         send_pulse(p, 1, '0, 2);
         idle_cycles(3);
      end
      dump_collect(1'b1);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL rnd_timeout: got %b expected 0", timed_out); end
      checks++; if (n_got !== 32) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected 32", n_got); end
      checks++; if (stall_errs !== 0) begin errors++; $display("[TB] FAIL rnd_stable: got %0d unstable stalls expected 0", stall_errs); end
      for (int i = 0; i < n_got && i < 32; i++) begin
         checks++; if (got_data[i] !== DW_ACC'(3 * i + 3)) begin errors++; $display("[TB] FAIL rnd_word[%0d]: got %0d expected %0d", i, got_data[i], 3 * i + 3); end
         checks++; if (got_last[i] !== (i == 31)) begin errors++; $display("[TB] FAIL rnd_last[%0d]: got %b expected %b", i, got_last[i], (i == 31)); end
      end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_busy_end: got %b expected 0", busy_o); end
   endtask

   // n_range_bins_i=9 clamps to MAX_RB=4, so 64 words
   task automatic test_saturation();
      start_frame(16'd9, 16'd3);
      for (int p = 0; p < 3; p++) begin
         send_pulse(p, 0, 32'hFFFF_FFFF, 4);
         idle_cycles(2);
      end
      dump_collect(1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL sat_timeout: got %b expected 0", timed_out); end
      checks++; if (n_got !== 64) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 64", n_got); end
      for (int i = 0; i < n_got && i < 64; i++) begin
         checks++; if (got_data[i] !== 33'h1_FFFF_FFFF) begin errors++; $display("[TB] FAIL sat_word[%0d]: got %0h expected 1ffffffff", i, got_data[i]); end
      end
      checks++; if (sat_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag: got %b expected 1", sat_o); end
   endtask

   task automatic test_overrun();
      start_frame(16'd2, 16'd3);
      for (int p = 0; p < 3; p++) begin
         send_pulse(p, 0, 32'd4, 2);
         idle_cycles(2);
      end
      for (int i = 0; i < 10; i++) apply_sample(32'd999, 1'b0);
      dump_collect(1'b0);
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun_o); end
      checks++; if (n_got !== 32) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 32", n_got); end
      for (int i = 0; i < n_got && i < 32; i++) begin
         checks++; if (got_data[i] !== 33'd12) begin errors++; $display("[TB] FAIL ovr_word[%0d]: got %0d expected 12", i, got_data[i]); end
      end
   endtask

   task automatic test_reset_mid();
      start_frame(16'd2, 16'd3);
      send_pulse(0, 0, 32'd7, 2);
      rst_i = 1'b1;
      idle_cycles(1);
      rst_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy_o); end
      checks++; if ({overrun_o, sat_o} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_flags: got %b expected 00", {overrun_o, sat_o}); end
      for (int i = 0; i < 5; i++) apply_sample(32'd50, 1'b1);
      checks++; if ({busy_o, overrun_o, frame_err_o} !== 3'b000) begin errors++; $display("[TB] FAIL idle_ignore: got %b expected 000", {busy_o, overrun_o, frame_err_o}); end
      start_frame(16'd2, 16'd3);
      for (int p = 0; p < 3; p++) begin
         send_pulse(p, 0, 32'd2, 2);
         idle_cycles(2);
      end
      dump_collect(1'b0);
      checks++; if (n_got !== 32) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 32", n_got); end
      for (int i = 0; i < n_got && i < 32; i++) begin
         checks++; if (got_data[i] !== 33'd6) begin errors++; $display("[TB] FAIL rstmid_word[%0d]: got %0d expected 6", i, got_data[i]); end
      end
   endtask

   // Zero register values clamp to 1 bin / 1 pulse; early last at bin 10 wraps
   // the whole frame, leaving bins 11..15 with the previous frame's value 6.
   task automatic test_frame_err();
      checks++; if (frame_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ferr_before: got %b expected 0", frame_err_o); end
      start_frame(16'd0, 16'd0);
      for (int k = 0; k <= 10; k++) apply_sample(DW_IN'(k + 100), k == 10);
      checks++; if (frame_err_o !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", frame_err_o); end
      dump_collect(1'b0);
      checks++; if (n_got !== 16) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected 16", n_got); end
      for (int i = 0; i < n_got && i < 16; i++) begin
         checks++; if (got_data[i] !== ((i <= 10) ? DW_ACC'(i + 100) : 33'd6)) begin errors++; $display("[TB] FAIL ferr_word[%0d]: got %0d expected %0d", i, got_data[i], (i <= 10) ? i + 100 : 6); end
         checks++; if (got_last[i] !== (i == 15)) begin errors++; $display("[TB] FAIL ferr_last[%0d]: got %b expected %b", i, got_last[i], (i == 15)); end
      end
   endtask

   initial begin
      rst_i          = 1'b1;
      enable_i       = 1'b0;
      n_range_bins_i = '0;
      n_acc_pulses_i = '0;
      pwr_i          = '0;
      pwr_valid_i    = 1'b0;
      pwr_last_i     = 1'b0;
      acc_ready_i    = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_constant();
      test_back_to_back();
      test_random_ready();
      test_saturation();
      test_overrun();
      test_reset_mid();
      test_frame_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
